// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared constants, op codes and FSM states for the frame-store command engine
package gfx_pkg;
    localparam int STRIDE   = 320;
    localparam int ROWS     = 480;
    localparam int FB_BYTES = STRIDE * ROWS;

    localparam logic [1:0] OP_FILL = 2'd0;
    localparam logic [1:0] OP_CLS  = 2'd1;
    localparam logic [1:0] OP_SWAP = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_CLS,
        ST_SWAP_WAIT,
        ST_DONE
    } state_t;

    // y*320 as (y<<8)+(y<<6) so no multiplier is needed for the row base
    function automatic logic [19:0] row_base_320(input logic [8:0] y);
        return ({11'd0, y} << 8) + ({11'd0, y} << 6);
    endfunction
endpackage

// File: rtl/gfx_rect_walker.sv
// rtl/gfx_rect_walker.sv - row-major byte address generator for a clipped rectangle
module gfx_rect_walker #(
    parameter int STRIDE = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    input  logic [9:0]  x_end,
    input  logic [9:0]  y_end,
    output logic        valid,
    output logic        last,
    output logic [19:0] addr
);
    import gfx_pkg::*;

    logic [9:0]  col, row, x_lo, col_hi, row_hi;
    logic [19:0] row_base, row0;
    logic        col_end, row_end;

    assign row0    = (STRIDE == 320) ? row_base_320(y) : 20'(y * STRIDE);
    assign col_end = (col == col_hi);
    assign row_end = (row == row_hi);
    assign last    = valid && col_end && row_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid    <= 1'b0;
            addr     <= '0;
            row_base <= '0;
            col      <= '0;
            row      <= '0;
            x_lo     <= '0;
            col_hi   <= '0;
            row_hi   <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            x_lo     <= {1'b0, x};
            col      <= {1'b0, x};
            row      <= {1'b0, y};
            col_hi   <= x_end - 10'd1;
            row_hi   <= y_end - 10'd1;
            row_base <= row0;
            addr     <= row0 + {11'd0, x};
        end else if (valid) begin
            if (!col_end) begin
                col  <= col + 10'd1;
                addr <= addr + 20'd1;
            end else if (!row_end) begin
                // wrap to the left edge of the next row; addr is kept as a register
                row      <= row + 10'd1;
                col      <= x_lo;
                row_base <= row_base + 20'(STRIDE);
                addr     <= row_base + 20'(STRIDE) + {10'd0, x_lo};
            end else begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/gfx_cmd_engine.sv
// rtl/gfx_cmd_engine.sv - command engine driving frame-store writes, clear handshake and buffer swap
module gfx_cmd_engine #(
    parameter int   STRIDE       = 320,
    parameter int   ROWS         = 480,
    parameter logic VSYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [8:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [8:0]  cmd_w,
    input  logic [8:0]  cmd_h,
    input  logic [7:0]  cmd_data,
    output logic        done,
    output logic [19:0] vmem_in_addr,
    output logic [7:0]  vmem_in_data,
    output logic        vmem_we,
    output logic        clsrq,
    input  logic        clsack,
    output logic        bufswap,
    input  logic        vsync
);
    import gfx_pkg::*;

    state_t     state, state_nxt;
    logic       accept, fill_nonempty, wk_load, wk_valid, wk_last;
    logic       vs_active, vs_prev, vs_edge;
    logic [9:0] x_sum, y_sum, x_end, y_end;
    logic [7:0] fill_data;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign x_sum = {1'b0, cmd_x} + {1'b0, cmd_w};
    assign y_sum = {1'b0, cmd_y} + {1'b0, cmd_h};
    assign x_end = (x_sum > 10'(STRIDE)) ? 10'(STRIDE) : x_sum;
    assign y_end = (y_sum > 10'(ROWS))   ? 10'(ROWS)   : y_sum;
    assign fill_nonempty = (cmd_w != 9'd0) && (cmd_h != 9'd0) &&
                           ({1'b0, cmd_x} < 10'(STRIDE)) && ({1'b0, cmd_y} < 10'(ROWS));
    assign wk_load = accept && (cmd_op == OP_FILL) && fill_nonempty;

    assign vs_active = (vsync == VSYNC_ACTIVE);
    assign vs_edge   = vs_active && !vs_prev;

    gfx_rect_walker #(.STRIDE(STRIDE)) u_walker (
        .clk   (clk),
        .rst   (rst),
        .load  (wk_load),
        .x     (cmd_x),
        .y     (cmd_y),
        .x_end (x_end),
        .y_end (y_end),
        .valid (wk_valid),
        .last  (wk_last),
        .addr  (vmem_in_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_FILL: state_nxt = ST_FILL;
                        OP_CLS:  state_nxt = ST_CLS;
                        OP_SWAP: state_nxt = ST_SWAP_WAIT;
                        default: state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_FILL:      if (!wk_valid || wk_last) state_nxt = ST_DONE;
            ST_CLS:       if (clsack)               state_nxt = ST_DONE;
            ST_SWAP_WAIT: if (vs_edge)              state_nxt = ST_DONE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vs_prev   <= 1'b0;
            bufswap   <= 1'b0;
            fill_data <= '0;
        end else begin
            vs_prev <= vs_active;
            if (accept && (cmd_op == OP_FILL)) fill_data <= cmd_data;
            if ((state == ST_SWAP_WAIT) && vs_edge) bufswap <= ~bufswap;
        end
    end

    assign done         = (state == ST_DONE);
    assign clsrq        = (state == ST_CLS);
    assign vmem_we      = wk_valid;
    assign vmem_in_data = fill_data;
endmodule

// File: tb/tb_gfx_cmd_engine.sv
// tb/tb_gfx_cmd_engine.sv - self-checking bench for gfx_cmd_engine
module tb_gfx_cmd_engine;
    import gfx_pkg::*;

    localparam logic VS_ACT = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [8:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [7:0]  cmd_data = '0;
    logic        clsack = 1'b0;
    logic        vsync = ~VS_ACT;
    logic        cmd_ready, done, vmem_we, clsrq, bufswap;
    logic [19:0] vmem_in_addr;
    logic [7:0]  vmem_in_data;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_buf = 1'b0;

    typedef struct {
        int x, y, w, h;
        logic [7:0] d;
        int n, first, last;
    } vec_t;
    vec_t tbl[8];

    gfx_cmd_engine #(.STRIDE(STRIDE), .ROWS(ROWS), .VSYNC_ACTIVE(VS_ACT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_data(cmd_data),
        .done(done), .vmem_in_addr(vmem_in_addr), .vmem_in_data(vmem_in_data), .vmem_we(vmem_we),
        .clsrq(clsrq), .clsack(clsack), .bufswap(bufswap), .vsync(vsync)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called at a negedge; returns at the negedge one cycle after accept
    task automatic issue(input logic [1:0] op, input int x, input int y, input int w, input int h,
                         input logic [7:0] d);
        cmd_op = op; cmd_x = 9'(x); cmd_y = 9'(y); cmd_w = 9'(w); cmd_h = 9'(h); cmd_data = d;
        cmd_valid = 1'b1;
        check("issue_ready", cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_fill(input int x, input int y, input int w, input int h, input logic [7:0] d,
                            output int nwr, output int first_a, output int last_a);
        int exp_q[$];
        int xe, ye, cyc, n_exp, last_exp;
        xe = (x + w > STRIDE) ? STRIDE : x + w;
        ye = (y + h > ROWS) ? ROWS : y + h;
        for (int r = y; r < ye; r++)
            for (int c = x; c < xe; c++)
                exp_q.push_back(r * STRIDE + c);
        n_exp = exp_q.size();
        last_exp = (n_exp > 0) ? exp_q[n_exp - 1] : 0;
        issue(OP_FILL, x, y, w, h, d);
        nwr = 0; first_a = -1; last_a = -1; cyc = 1;
        while (done !== 1'b1 && cyc <= n_exp + 5) begin
            check("fill_busy_ready", cmd_ready, 1'b0);
            if (vmem_we === 1'b1) begin
                check("fill_we_cycle", cyc, nwr + 1);
                if (nwr == 0) first_a = int'(vmem_in_addr);
                last_a = int'(vmem_in_addr);
                if (exp_q.size() == 0) check("fill_extra_write", 1, 0);
                else check("fill_addr", vmem_in_addr, exp_q.pop_front());
                check("fill_data", vmem_in_data, d);
                nwr++;
            end
            @(negedge clk);
            cyc++;
        end
        check("fill_done_cycle", cyc, (n_exp == 0) ? 2 : n_exp + 1);
        check("fill_done_we", vmem_we, 1'b0);
        check("fill_missing_writes", exp_q.size(), 0);
        if (n_exp > 0) check("fill_addr_hold", vmem_in_addr, last_exp);
        @(negedge clk);
        check("fill_ready_after", cmd_ready, 1'b1);
        check("fill_done_single", done, 1'b0);
    endtask

    task automatic run_swap();
        int bad;
        bad = 0;
        vsync = VS_ACT;
        issue(OP_SWAP, 0, 0, 0, 0, 8'h00);
        vsync = ~VS_ACT;
        for (int i = 0; i < 100; i++) begin
            if (bufswap !== exp_buf || done !== 1'b0) bad++;
            @(negedge clk);
        end
        check("swap_wait_hold", bad, 0);
        vsync = VS_ACT;
        @(negedge clk);
        exp_buf = ~exp_buf;
        check("swap_done", done, 1'b1);
        check("swap_bufswap", bufswap, exp_buf);
        @(negedge clk);
        check("swap_ready_after", cmd_ready, 1'b1);
    endtask

    initial begin
        int nwr, fa, la, hi, we_seen, cyc, ready_cyc, rq_cyc, overlap;

        tbl[0] = '{10, 2, 3, 2, 8'hA5, 6, 650, 972};
        tbl[1] = '{318, 479, 5, 4, 8'h5A, 2, 153598, 153599};
        tbl[2] = '{40, 40, 0, 7, 8'h11, 0, -1, -1};
        tbl[3] = '{40, 40, 7, 0, 8'h22, 0, -1, -1};
        tbl[4] = '{320, 10, 4, 4, 8'h33, 0, -1, -1};
        tbl[5] = '{10, 480, 4, 4, 8'h44, 0, -1, -1};
        tbl[6] = '{0, 0, 1, 1, 8'hFF, 1, 0, 0};
        tbl[7] = '{300, 10, 40, 1, 8'h7E, 20, 3500, 3519};

        repeat (2) @(negedge clk);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_we", vmem_we, 1'b0);
        check("rst_addr", vmem_in_addr, 20'd0);
        check("rst_data", vmem_in_data, 8'd0);
        check("rst_clsrq", clsrq, 1'b0);
        check("rst_bufswap", bufswap, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_fill(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].d, nwr, fa, la);
            check("tbl_count", nwr, tbl[i].n);
            check("tbl_first", fa, tbl[i].first);
            check("tbl_last", la, tbl[i].last);
        end

        clsack = 1'b1;
        @(negedge clk);
        clsack = 1'b0;
        check("idle_ack_clsrq", clsrq, 1'b0);
        check("idle_ack_done", done, 1'b0);

        issue(OP_CLS, 0, 0, 0, 0, 8'h00);
        hi = 0; we_seen = 0;
        while (clsrq === 1'b1 && hi < 100) begin
            hi++;
            if (vmem_we === 1'b1) we_seen++;
            if (hi == 20) clsack = 1'b1;
            @(negedge clk);
            clsack = 1'b0;
        end
        check("cls_high_cycles", hi, 20);
        check("cls_done", done, 1'b1);
        check("cls_no_we", we_seen, 0);
        @(negedge clk);
        check("cls_ready_after", cmd_ready, 1'b1);

        issue(2'd3, 0, 0, 0, 0, 8'h00);
        check("rsvd_done", done, 1'b1);
        check("rsvd_no_side", {vmem_we, clsrq}, 2'b00);
        @(negedge clk);

        for (int i = 0; i < 3; i++) run_swap();

        issue(OP_FILL, 0, 5, 100, 1, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            check("rstmid_we", vmem_we, 1'b1);
            check("rstmid_addr", vmem_in_addr, 20'(5 * STRIDE + i));
            if (i < 2) @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_buf = 1'b0;
        check("rstmid_we_off", vmem_we, 1'b0);
        check("rstmid_ready", cmd_ready, 1'b1);
        check("rstmid_bufswap", bufswap, 1'b0);
        check("rstmid_clsrq", clsrq, 1'b0);
        we_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (vmem_we !== 1'b0) we_seen++;
        end
        check("rstmid_no_more_writes", we_seen, 0);
        run_fill(7, 9, 5, 3, 8'hC3, nwr, fa, la);

        cmd_op = OP_FILL; cmd_x = 9'd0; cmd_y = 9'd0; cmd_w = 9'd4; cmd_h = 9'd1; cmd_data = 8'h99;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_op = OP_CLS;
        cyc = 1; ready_cyc = 0; rq_cyc = 0; overlap = 0;
        while (rq_cyc == 0 && cyc < 50) begin
            if (vmem_we === 1'b1 && clsrq === 1'b1) overlap++;
            if (cmd_ready === 1'b1 && ready_cyc == 0) ready_cyc = cyc;
            if (clsrq === 1'b1) rq_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        cmd_valid = 1'b0;
        check("b2b_ready_cycle", ready_cyc, 6);
        check("b2b_cls_accept", rq_cyc, ready_cyc + 1);
        check("b2b_overlap", overlap, 0);
        clsack = 1'b1;
        @(negedge clk);
        clsack = 1'b0;
        check("b2b_cls_done", done, 1'b1);
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            int rx, ry, rw, rh;
            if ($urandom_range(0, 5) == 0) begin
                issue(2'd3, 0, 0, 0, 0, 8'h00);
                check("rnd_rsvd_done", done, 1'b1);
                @(negedge clk);
            end else begin
                rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 330)) : int'($urandom_range(0, 319));
                ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(470, 490)) : int'($urandom_range(0, 479));
                rw = int'($urandom_range(0, 12));
                rh = int'($urandom_range(0, 5));
                run_fill(rx, ry, rw, rh, 8'($urandom), nwr, fa, la);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gfx_cmd_engine.md
Name: gfx_cmd_engine

Overview:
- CPU-side producer for the double-buffered greyscale frame store; drives the frame store's write port and its clear and swap controls.
- Accepts one command at a time: rectangle fill, full clear, or vsync-aligned buffer swap.
- Fill generates one byte write per clock into the back buffer.
- Clear and swap run the clsrq/clsack handshake and the bufswap level toward the VGA top.

Parameters:
- STRIDE, 320: bytes per row (two 4-bit pixels per byte).
- ROWS, 480: rows per frame (STRIDE*ROWS = 153600 bytes).
- VSYNC_ACTIVE, 0: active level of the vsync input.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle and able to accept a command.
- cmd_op  in  2  0=FILL, 1=CLS, 2=SWAP, 3=reserved.
- cmd_x  in  9  left byte column.
- cmd_y  in  9  top row.
- cmd_w  in  9  width in bytes.
- cmd_h  in  9  height in rows.
- cmd_data  in  8  fill byte.
- done  out  1  one-cycle pulse when a command completes.
- vmem_in_addr  out  20  write byte address.
- vmem_in_data  out  8  write data.
- vmem_we  out  1  write strobe.
- clsrq  out  1  clear request, held until acknowledged.
- clsack  in  1  clear acknowledge pulse.
- bufswap  out  1  front/back buffer select level.
- vsync  in  1  VGA vertical sync.

Behaviour:
- Reset (rst==0 at posedge):
  - State IDLE.
  - cmd_ready=1; done=0; vmem_we=0; vmem_in_addr=0; vmem_in_data=0; clsrq=0; bufswap=0.
  - Reset mid-operation abandons the command without issuing further writes. clsrq drops.
- Accept: a command is taken on the cycle cmd_valid && cmd_ready. cmd_ready drops the next cycle and stays 0 until the cycle after done.
- FILL:
  - Clip: x_end = min(x+w, STRIDE); y_end = min(y+h, ROWS). Compute in 10 bits.
  - If w==0, h==0, x>=STRIDE or y>=ROWS: no writes; done pulses 2 cycles after accept.
  - Otherwise the first write appears 1 cycle after accept, at addr y*STRIDE+x.
  - Writes are contiguous, one per cycle, row-major. Columns run x..x_end-1, then the next row.
  - Row base advances by adding STRIDE. No multiplier in the per-pixel loop; the single y*STRIDE at accept is formed as (y<<8)+(y<<6).
  - The cycle after the last write: vmem_we=0 and done=1.
  - Total writes = (x_end-x)*(y_end-y).
- CLS:
  - clsrq is set 1 the cycle after accept.
  - It is held while clsack==0.
  - On the cycle clsack==1 is sampled: clsrq<=0 and done<=1.
  - No vmem_we during CLS.
  - clsack arriving while not in CLS is ignored.
- SWAP:
  - Wait for vsync to transition from inactive to VSYNC_ACTIVE, using a registered previous sample.
  - The cycle after that edge is detected: bufswap toggles and done pulses.
  - A vsync already active at accept does not count; the engine waits for the next edge.
- States: IDLE, FILL, CLS, SWAP_WAIT, DONE.
  - DONE lasts 1 cycle: done=1, then IDLE.
  - A reserved op goes IDLE->DONE with no side effects.
- vmem_in_addr and vmem_in_data are registered outputs. They hold their last value when vmem_we=0.
- Max address = STRIDE*ROWS-1 = 153599. Never exceeded, by the clipping rule.

Decomposition:
- Package gfx_pkg:
  - op code constants OP_FILL, OP_CLS, OP_SWAP.
  - STRIDE, ROWS, FB_BYTES=153600.
  - state encoding.
- Sub-module gfx_rect_walker:
  - Loads (x, y, x_end, y_end) and emits addr/valid/last each cycle using a column counter and a row-base accumulator.
  - The top FSM owns the handshakes and swap/clear.

Test Plan:
- FILL x=10 y=2 w=3 h=2 data=0xA5 -> we high 6 consecutive cycles starting 1 cycle after accept, addresses 650,651,652,970,971,972, data 0xA5. done 1 cycle after the last write. cmd_ready back 1 cycle later.
- FILL x=318 y=479 w=5 h=4 -> exactly 2 writes, addrs 153598, 153599. FILL w=0 -> zero writes; done 2 cycles after accept.
- CLS with clsack model pulsing 20 cycles after clsrq rises -> clsrq high for exactly 20 cycles, drops the cycle after the ack sample, done coincident with the drop. No vmem_we in the window.
- SWAP issued with vsync already at 0 (active), then goes 1 and back to 0 after 100 cycles -> bufswap toggles 0->1 only after that second falling edge. A second SWAP returns it to 0.
- Reset asserted mid-FILL (after 3 of 100 writes) -> next cycle we=0, cmd_ready=1, bufswap=0. A new FILL after reset behaves normally.
- Back-to-back: FILL then CLS with cmd_valid held high -> CLS accepted exactly the cycle cmd_ready returns. No overlap of vmem_we and clsrq.
